// File: rtl/zxsdcard_multi.sv
// Multi-slot SD card power/initialisation sequencer with SPI pass-through and card-detect debounce.
// Optional hot-plug handling (EMPTY state) is enabled by defining SD_HOTPLUG_EN.
module zxsdcard_multi #(
    parameter int NUM_SLOTS          = 2,
    parameter int POWERDOWN_CYCLES   = 4096,
    parameter int POWERUP_CYCLES     = 4096,
    parameter int STARTUP_CLKS       = 80,
    parameter int SCK_HALF_PERIOD    = 64,
    parameter int CD_DEBOUNCE_CYCLES = 65536
) (
    input  logic                 clk_peripheral,
    input  logic                 reset,
    output logic [NUM_SLOTS-1:0] sd_pwr_n,
    input  logic [NUM_SLOTS-1:0] sd_cd_n,
    output logic [NUM_SLOTS-1:0] sd_sck,
    output logic [NUM_SLOTS-1:0] sd_cmd,
    input  logic [NUM_SLOTS-1:0] sd_dat0,
    output logic [NUM_SLOTS-1:0] sd_cs_n,
    input  logic                 in_sck,
    input  logic                 in_mosi,
    output logic                 in_miso,
    output logic                 out_sck,
    output logic                 out_mosi,
    input  logic                 out_miso,
    input  logic [NUM_SLOTS-1:0] enable_n,
    input  logic [NUM_SLOTS-1:0] pwrcycle_req,
    output logic [NUM_SLOTS-1:0] slot_ready,
    output logic [NUM_SLOTS-1:0] card_present
);

    localparam int CNT_MAX0 = (POWERDOWN_CYCLES > POWERUP_CYCLES) ? POWERDOWN_CYCLES : POWERUP_CYCLES;
    localparam int CNT_MAX  = (CNT_MAX0 > SCK_HALF_PERIOD) ? CNT_MAX0 : SCK_HALF_PERIOD;
    localparam int CNT_W    = $clog2(CNT_MAX) + 1;
    localparam int EDGE_W   = $clog2(STARTUP_CLKS) + 1;
    localparam int DEB_W    = $clog2(CD_DEBOUNCE_CYCLES) + 1;

`ifdef SD_HOTPLUG_EN
    typedef enum logic [2:0] {ST_OFF, ST_RAMP, ST_INIT, ST_READY, ST_EMPTY} state_t;
`else
    typedef enum logic [1:0] {ST_OFF, ST_RAMP, ST_INIT, ST_READY} state_t;
`endif

    logic [NUM_SLOTS-1:0] rdy;

    assign out_sck  = in_sck;
    assign out_mosi = in_mosi;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        state_t              state;
        logic [CNT_W-1:0]    cnt;
        logic [EDGE_W-1:0]   edges;
        logic                sck_q;
        logic                cd_s1;
        logic                cd_s2;
        logic                present;
        logic [DEB_W-1:0]    deb_cnt;
        logic                deb_flip;

        // The debounced state flips on the last of CD_DEBOUNCE_CYCLES disagreeing samples.
        assign deb_flip = (~cd_s2 != present) && (deb_cnt == DEB_W'(CD_DEBOUNCE_CYCLES - 1));

        always_ff @(posedge clk_peripheral) begin
            if (reset) begin
                cd_s1   <= 1'b1;
                cd_s2   <= 1'b1;
                present <= 1'b0;
                deb_cnt <= '0;
            end else begin
                cd_s1 <= sd_cd_n[i];
                cd_s2 <= cd_s1;
                if (~cd_s2 == present) begin
                    deb_cnt <= '0;
                end else if (deb_flip) begin
                    present <= ~cd_s2;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end
        end

        always_ff @(posedge clk_peripheral) begin
            if (reset) begin
                state <= ST_OFF;
                cnt   <= CNT_W'(POWERDOWN_CYCLES - 1);
                edges <= '0;
                sck_q <= 1'b0;
`ifdef SD_HOTPLUG_EN
            end else if (deb_flip && present) begin
                state <= ST_EMPTY;
                sck_q <= 1'b0;
            end else if (pwrcycle_req[i] && state != ST_EMPTY) begin
`else
            end else if (pwrcycle_req[i]) begin
`endif
                state <= ST_OFF;
                cnt   <= CNT_W'(POWERDOWN_CYCLES - 1);
                edges <= '0;
                sck_q <= 1'b0;
            end else begin
                case (state)
                    ST_OFF: begin
                        if (cnt == '0) begin
`ifdef SD_HOTPLUG_EN
                            state <= present ? ST_RAMP : ST_EMPTY;
`else
                            state <= ST_RAMP;
`endif
                            cnt   <= CNT_W'(POWERUP_CYCLES - 1);
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_RAMP: begin
                        if (cnt == '0) begin
                            state <= ST_INIT;
                            cnt   <= CNT_W'(SCK_HALF_PERIOD - 1);
                            edges <= '0;
                            sck_q <= 1'b0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_INIT: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            cnt <= CNT_W'(SCK_HALF_PERIOD - 1);
                            if (sck_q) begin
                                // Falling edge after the last startup pulse hands the slot to the host.
                                sck_q <= 1'b0;
                                if (edges == EDGE_W'(STARTUP_CLKS))
                                    state <= ST_READY;
                            end else begin
                                sck_q <= 1'b1;
                                edges <= edges + 1'b1;
                            end
                        end
                    end
                    ST_READY: begin
                        state <= ST_READY;
                    end
`ifdef SD_HOTPLUG_EN
                    ST_EMPTY: begin
                        if (present) begin
                            state <= ST_OFF;
                            cnt   <= CNT_W'(POWERDOWN_CYCLES - 1);
                            edges <= '0;
                            sck_q <= 1'b0;
                        end
                    end
`endif
                    default: begin
                        state <= ST_OFF;
                        cnt   <= CNT_W'(POWERDOWN_CYCLES - 1);
                    end
                endcase
            end
        end

`ifdef SD_HOTPLUG_EN
        assign sd_pwr_n[i] = (state == ST_OFF) || (state == ST_EMPTY);
`else
        assign sd_pwr_n[i] = (state == ST_OFF);
`endif
        assign rdy[i]          = (state == ST_READY);
        assign sd_sck[i]       = rdy[i] ? in_sck      : ((state == ST_INIT) && sck_q);
        assign sd_cmd[i]       = rdy[i] ? in_mosi     : (state == ST_INIT);
        assign sd_cs_n[i]      = rdy[i] ? enable_n[i] : (state == ST_INIT);
        assign slot_ready[i]   = rdy[i];
        assign card_present[i] = present;
    end

    // Lowest-numbered selected ready slot wins the host MISO line.
    always_comb begin
        in_miso = out_miso;
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            if (!enable_n[k] && rdy[k])
                in_miso = sd_dat0[k];
        end
    end

endmodule

// File: tb/tb_zxsdcard_multi.sv
// Bench for zxsdcard_multi: timeline reference model, pass-through vector table, corner-case sequences.
module tb_zxsdcard_multi;

    localparam int N   = 2;
    localparam int PD  = 8;
    localparam int PU  = 8;
    localparam int SC  = 4;
    localparam int SH  = 2;
    localparam int DEB = 4;
    localparam int T_INIT  = PD + PU;
    localparam int T_READY = PD + PU + 2 * SH * SC;
`ifdef SD_HOTPLUG_EN
    localparam bit HOTPLUG = 1'b1;
`else
    localparam bit HOTPLUG = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic [N-1:0] sd_pwr_n, sd_cd_n, sd_sck, sd_cmd, sd_dat0, sd_cs_n;
    logic         in_sck, in_mosi, in_miso, out_sck, out_mosi, out_miso;
    logic [N-1:0] enable_n, pwrcycle_req, slot_ready, card_present;

    int vectors = 0;
    int errors  = 0;

    // Reference model: cycles elapsed since each slot's sequence began, plus card-detect view.
    int t_m[N];
    bit present_m[N];
    bit dly_m[N][2];
    int run_m[N];

    zxsdcard_multi #(
        .NUM_SLOTS(N), .POWERDOWN_CYCLES(PD), .POWERUP_CYCLES(PU),
        .STARTUP_CLKS(SC), .SCK_HALF_PERIOD(SH), .CD_DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk_peripheral(clk), .reset(reset), .sd_pwr_n(sd_pwr_n), .sd_cd_n(sd_cd_n),
        .sd_sck(sd_sck), .sd_cmd(sd_cmd), .sd_dat0(sd_dat0), .sd_cs_n(sd_cs_n),
        .in_sck(in_sck), .in_mosi(in_mosi), .in_miso(in_miso), .out_sck(out_sck),
        .out_mosi(out_mosi), .out_miso(out_miso), .enable_n(enable_n),
        .pwrcycle_req(pwrcycle_req), .slot_ready(slot_ready), .card_present(card_present)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [N-1:0] e_pwr, e_rdy, e_sck, e_cmd, e_cs, e_cp;
        logic e_miso;
        bit found;
        for (int i = 0; i < N; i++) begin
            e_pwr[i] = (t_m[i] < PD);
            e_rdy[i] = (t_m[i] >= T_READY);
            e_cp[i]  = present_m[i];
            if (t_m[i] < T_INIT) begin
                e_sck[i] = 1'b0; e_cmd[i] = 1'b0; e_cs[i] = 1'b0;
            end else if (t_m[i] < T_READY) begin
                e_sck[i] = (((t_m[i] - T_INIT) / SH) % 2) == 1;
                e_cmd[i] = 1'b1; e_cs[i] = 1'b1;
            end else begin
                e_sck[i] = in_sck; e_cmd[i] = in_mosi; e_cs[i] = enable_n[i];
            end
        end
        e_miso = out_miso;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && !enable_n[k] && e_rdy[k]) begin
                e_miso = sd_dat0[k];
                found = 1'b1;
            end
        end
        chk("sd_pwr_n", 32'(sd_pwr_n), 32'(e_pwr));
        chk("slot_ready", 32'(slot_ready), 32'(e_rdy));
        chk("sd_sck", 32'(sd_sck), 32'(e_sck));
        chk("sd_cmd", 32'(sd_cmd), 32'(e_cmd));
        chk("sd_cs_n", 32'(sd_cs_n), 32'(e_cs));
        chk("card_present", 32'(card_present), 32'(e_cp));
        chk("in_miso", 32'(in_miso), 32'(e_miso));
        chk("out_pass", {30'd0, out_sck, out_mosi}, {30'd0, in_sck, in_mosi});
    endtask

    task automatic model_edge();
        bit samp;
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                t_m[i] = 0; present_m[i] = 1'b0; dly_m[i][0] = 1'b1; dly_m[i][1] = 1'b1; run_m[i] = 0;
            end else begin
                if (pwrcycle_req[i]) t_m[i] = 0;
                else if (t_m[i] < T_READY) t_m[i]++;
                samp = ~dly_m[i][1];
                dly_m[i][1] = dly_m[i][0];
                dly_m[i][0] = sd_cd_n[i];
                if (samp == present_m[i]) run_m[i] = 0;
                else run_m[i]++;
                if (run_m[i] == DEB) begin
                    present_m[i] = samp; run_m[i] = 0;
                end
            end
        end
    endtask

    // Inputs are driven at the falling edge; outputs checked 2 time units later.
    task automatic tick(input bit do_chk);
        #2;
        if (do_chk) check_model();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    typedef struct packed {
        logic [N-1:0] en;
        logic [N-1:0] dat0;
        logic         omiso;
        logic         isck;
        logic         imosi;
        logic         e_miso;
        logic [N-1:0] e_sck;
        logic [N-1:0] e_cmd;
        logic [N-1:0] e_cs;
    } pt_vec_t;

    pt_vec_t tbl[8];
    int rises;
    logic prev_sck;

    initial begin
        tbl[0] = '{2'b10, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 2'b00, 2'b10};
        tbl[1] = '{2'b11, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b11, 2'b11};
        tbl[2] = '{2'b11, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 2'b11, 2'b11};
        tbl[3] = '{2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b01};
        tbl[4] = '{2'b00, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00};
        tbl[5] = '{2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b11, 2'b00};
        tbl[6] = '{2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10};
        tbl[7] = '{2'b01, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 2'b11, 2'b01};

        reset = 1'b1; sd_cd_n = '0; sd_dat0 = '0; in_sck = 1'b0; in_mosi = 1'b0;
        out_miso = 1'b0; enable_n = '1; pwrcycle_req = '0;
        @(negedge clk);
        tick(1'b0);
        tick(1'b1);
        tick(1'b1);
        reset = 1'b0;

        // Power-up sequence from reset, counting INIT clock pulses on slot 0.
        rises = 0;
        prev_sck = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick(1'b1);
            if (sd_sck[0] && !prev_sck && !slot_ready[0]) rises++;
            if (sd_sck[0] && !slot_ready[0]) chk("init_cs_n_high", 32'(sd_cs_n[0]), 32'd1);
            prev_sck = sd_sck[0];
        end
        chk("init_sck_pulses", 32'(rises), 32'(SC));

        // SPI pass-through table with both slots ready.
        for (int v = 0; v < 8; v++) begin
            enable_n = tbl[v].en; sd_dat0 = tbl[v].dat0; out_miso = tbl[v].omiso;
            in_sck = tbl[v].isck; in_mosi = tbl[v].imosi;
            #2;
            chk("tbl_in_miso", 32'(in_miso), 32'(tbl[v].e_miso));
            chk("tbl_sd_sck", 32'(sd_sck), 32'(tbl[v].e_sck));
            chk("tbl_sd_cmd", 32'(sd_cmd), 32'(tbl[v].e_cmd));
            chk("tbl_sd_cs_n", 32'(sd_cs_n), 32'(tbl[v].e_cs));
            tick(1'b1);
        end
        enable_n = '1;

        // Power-cycle request on slot 1 only.
        pwrcycle_req = 2'b10;
        tick(1'b1);
        pwrcycle_req = '0;
        chk("pwrcycle_ready", 32'(slot_ready), 32'b01);
        chk("pwrcycle_pwr_n", 32'(sd_pwr_n), 32'b10);
        for (int c = 0; c < T_READY - 1; c++) tick(1'b1);
        chk("pwrcycle_not_yet", 32'(slot_ready), 32'b01);
        tick(1'b1);
        chk("pwrcycle_ready_again", 32'(slot_ready), 32'b11);

        // Card-detect glitch, then a real removal and reinsertion of slot 0.
        sd_cd_n[0] = 1'b1;
        for (int c = 0; c < 3; c++) tick(!HOTPLUG);
        sd_cd_n[0] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick(!HOTPLUG);
            chk("glitch_present", 32'(card_present[0]), 32'd1);
        end
        sd_cd_n[0] = 1'b1;
        for (int c = 0; c < DEB + 1; c++) tick(!HOTPLUG);
        chk("remove_present_hold", 32'(card_present[0]), 32'd1);
        tick(!HOTPLUG);
        chk("remove_present", 32'(card_present[0]), 32'd0);
        if (HOTPLUG) begin
            chk("empty_pwr_n", 32'(sd_pwr_n[0]), 32'd1);
            chk("empty_ready", 32'(slot_ready[0]), 32'd0);
        end else begin
            chk("no_hotplug_ready", 32'(slot_ready[0]), 32'd1);
        end
        sd_cd_n[0] = 1'b0;
        for (int c = 0; c < DEB + 2; c++) tick(!HOTPLUG);
        chk("insert_present", 32'(card_present[0]), 32'd1);
        if (HOTPLUG) begin
            chk("reinsert_pwr_n", 32'(sd_pwr_n[0]), 32'd1);
            for (int c = 0; c < T_READY; c++) tick(1'b0);
            chk("reinsert_not_yet", 32'(slot_ready[0]), 32'd0);
            tick(1'b0);
            chk("reinsert_ready", 32'(slot_ready[0]), 32'd1);
        end

        // Reset asserted while slot sck is high in INIT.
        reset = 1'b1;
        tick(1'b0);
        reset = 1'b0;
        for (int c = 0; c < T_INIT + 3; c++) tick(1'b1);
        chk("pre_reset_sck", 32'(sd_sck), 32'b11);
        reset = 1'b1;
        tick(1'b1);
        chk("reset_sck", 32'(sd_sck), 32'b00);
        chk("reset_pwr_n", 32'(sd_pwr_n), 32'b11);
        chk("reset_ready", 32'(slot_ready), 32'b00);
        chk("reset_present", 32'(card_present), 32'b00);
        reset = 1'b0;
        for (int c = 0; c < T_READY; c++) tick(1'b1);
        chk("restart_ready", 32'(slot_ready), 32'b11);

        // Randomised traffic checked every cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            in_sck = 1'($urandom_range(0, 1));
            in_mosi = 1'($urandom_range(0, 1));
            out_miso = 1'($urandom_range(0, 1));
            enable_n = N'($urandom_range(0, (1 << N) - 1));
            sd_dat0 = N'($urandom_range(0, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                pwrcycle_req[i] = ($urandom_range(0, 149) == 0);
                if (!HOTPLUG && $urandom_range(0, 24) == 0) sd_cd_n[i] = ~sd_cd_n[i];
            end
            reset = ($urandom_range(0, 999) == 0);
            tick(1'b1);
        end
        reset = 1'b0;
        pwrcycle_req = '0;
        tick(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
